// File: rtl/midi_encoder.sv
// MIDI channel-voice message serialiser: one handshake in, 2 or 3 bytes out,
// with optional running-status compression that expires after an idle period.
//
// state  | meaning
// IDLE   | msg_ready high, waiting for a message
// STATUS | status byte on data_out, waiting for transfer
// DATA1  | first data byte on data_out, waiting for transfer
// DATA2  | second data byte on data_out, waiting for transfer
module midi_encoder #(
    parameter bit          RUNNING_STATUS = 1'b0,
    parameter int unsigned RS_TIMEOUT     = 15_000_000
) (
    input  logic       clock_50_000_000,
    input  logic       reset_l,
    input  logic [3:0] msg_type,
    input  logic [3:0] msg_channel,
    input  logic [7:0] msg_data1,
    input  logic [7:0] msg_data2,
    input  logic       msg_valid,
    output logic       msg_ready,
    output logic       msg_error,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready
);

    localparam int TW = (RS_TIMEOUT < 2) ? 1 : $clog2(RS_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, STATUS, DATA1, DATA2} state_t;

    state_t      state;
    state_t      state_nxt;

    logic [7:0]  data1_q;
    logic [7:0]  data2_q;
    logic        three_q;

    logic [7:0]  data_out_nxt;
    logic        valid_nxt;
    logic        error_nxt;
    logic        load_msg;

    logic        type_ok;
    logic        type_three;
    logic [7:0]  status_in;
    logic        accept;
    logic        xfer;

    logic [7:0]  rs_byte;
    logic        rs_valid;
    logic        rs_hit;
    logic        rs_expire;
    logic [TW-1:0] rs_timer;

    assign msg_ready = (state == IDLE);
    assign accept    = msg_valid && msg_ready;
    assign xfer      = data_out_valid && data_out_ready;
    assign status_in = {msg_type, msg_channel};
    assign rs_hit    = RUNNING_STATUS && rs_valid && (rs_byte == status_in);
    assign rs_expire = !xfer && (rs_timer == TW'(1));

    always_comb begin
        type_ok    = 1'b0;
        type_three = 1'b0;
        case (msg_type)
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: begin
                type_ok    = 1'b1;
                type_three = 1'b1;
            end
            4'hC, 4'hD: type_ok = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        data_out_nxt = data_out;
        valid_nxt    = data_out_valid;
        error_nxt    = 1'b0;
        load_msg     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (type_ok) begin
                        load_msg  = 1'b1;
                        valid_nxt = 1'b1;
                        if (rs_hit) begin
                            state_nxt    = DATA1;
                            data_out_nxt = msg_data1 & 8'h7F;
                        end else begin
                            state_nxt    = STATUS;
                            data_out_nxt = status_in;
                        end
                    end else begin
                        error_nxt = 1'b1;
                    end
                end
            end
            STATUS: begin
                if (xfer) begin
                    state_nxt    = DATA1;
                    data_out_nxt = data1_q;
                end
            end
            DATA1: begin
                if (xfer) begin
                    if (three_q) begin
                        state_nxt    = DATA2;
                        data_out_nxt = data2_q;
                    end else begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                    end
                end
            end
            DATA2: begin
                if (xfer) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            data_out       <= 8'h00;
            data_out_valid <= 1'b0;
            msg_error      <= 1'b0;
            data1_q        <= 8'h00;
            data2_q        <= 8'h00;
            three_q        <= 1'b0;
        end else begin
            data_out       <= data_out_nxt;
            data_out_valid <= valid_nxt;
            msg_error      <= error_nxt;
            if (load_msg) begin
                data1_q <= msg_data1 & 8'h7F;
                data2_q <= msg_data2 & 8'h7F;
                three_q <= type_three;
            end
        end
    end

    // Idle timer counts down from RS_TIMEOUT after each transfer; the memory
    // is dropped on the cycle it would reach zero.
    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            rs_timer <= '0;
            rs_byte  <= 8'h00;
            rs_valid <= 1'b0;
        end else begin
            if (xfer) begin
                rs_timer <= TW'(RS_TIMEOUT);
            end else if (rs_timer != '0) begin
                rs_timer <= rs_timer - TW'(1);
            end
            if (xfer && state == STATUS) begin
                rs_byte  <= data_out;
                rs_valid <= 1'b1;
            end else if (rs_expire) begin
                rs_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_midi_encoder.sv
// Scoreboard bench for midi_encoder: one instance without running status,
// one with running status and a short idle timeout.
module tb_midi_encoder;

    logic clk;
    logic rst_n;

    logic [3:0] a_type, a_ch, b_type, b_ch;
    logic [7:0] a_d1, a_d2, b_d1, b_d2;
    logic       a_valid, a_rdy, a_err, a_dv, a_dr;
    logic       b_valid, b_rdy, b_err, b_dv, b_dr;
    logic [7:0] a_dout, b_dout;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    int n_checks = 0;
    int n_fail   = 0;

    midi_encoder #(.RUNNING_STATUS(1'b0)) dut_a (
        .clock_50_000_000(clk), .reset_l(rst_n),
        .msg_type(a_type), .msg_channel(a_ch), .msg_data1(a_d1), .msg_data2(a_d2),
        .msg_valid(a_valid), .msg_ready(a_rdy), .msg_error(a_err),
        .data_out(a_dout), .data_out_valid(a_dv), .data_out_ready(a_dr)
    );

    midi_encoder #(.RUNNING_STATUS(1'b1), .RS_TIMEOUT(8)) dut_b (
        .clock_50_000_000(clk), .reset_l(rst_n),
        .msg_type(b_type), .msg_channel(b_ch), .msg_data1(b_d1), .msg_data2(b_d2),
        .msg_valid(b_valid), .msg_ready(b_rdy), .msg_error(b_err),
        .data_out(b_dout), .data_out_valid(b_dv), .data_out_ready(b_dr)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic get_dv(input bit w);
        return w ? b_dv : a_dv;
    endfunction

    function automatic logic [7:0] get_dout(input bit w);
        return w ? b_dout : a_dout;
    endfunction

    function automatic logic get_rdy(input bit w);
        return w ? b_rdy : a_rdy;
    endfunction

    function automatic int qsize(input bit w);
        return w ? exp_b.size() : exp_a.size();
    endfunction

    task automatic set_ready(input bit w, input logic v);
        if (w) b_dr = v;
        else   a_dr = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one message for a single cycle and push the bytes it should produce.
    task automatic send(input bit w, input logic [3:0] t, input logic [3:0] ch,
                        input logic [7:0] d1, input logic [7:0] d2, input bit with_status);
        int n;
        logic [7:0] e[$];
        if (w) begin
            b_type = t; b_ch = ch; b_d1 = d1; b_d2 = d2; b_valid = 1'b1;
        end else begin
            a_type = t; a_ch = ch; a_d1 = d1; a_d2 = d2; a_valid = 1'b1;
        end
        n_checks++;
        if (get_rdy(w) !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_before_send dut%0d: msg_ready=%b, required 1", w, get_rdy(w));
        end
        tick();
        if (w) begin
            b_valid = 1'b0; b_type = 4'($urandom); b_ch = 4'($urandom);
            b_d1 = 8'($urandom); b_d2 = 8'($urandom);
        end else begin
            a_valid = 1'b0; a_type = 4'($urandom); a_ch = 4'($urandom);
            a_d1 = 8'($urandom); a_d2 = 8'($urandom);
        end
        case (t)
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: n = 3;
            4'hC, 4'hD:                   n = 2;
            default:                      n = 0;
        endcase
        if (n > 0) begin
            if (with_status) e.push_back({t, ch});
            e.push_back({1'b0, d1[6:0]});
            if (n == 3) e.push_back({1'b0, d2[6:0]});
        end
        foreach (e[i]) begin
            if (w) exp_b.push_back(e[i]);
            else   exp_a.push_back(e[i]);
        end
    endtask

    // Pop and compare every outstanding byte; stall holds ready low that many cycles per byte.
    task automatic drain(input bit w, input int stall, output int gap);
        int waited;
        logic [7:0] exp;
        gap = 0;
        waited = 0;
        set_ready(w, stall == 0);
        while (qsize(w) > 0 && waited < 200) begin
            if (get_dv(w) !== 1'b1) begin
                tick();
                waited++;
                gap++;
            end else begin
                exp = w ? exp_b.pop_front() : exp_a.pop_front();
                for (int i = 0; i < stall; i++) begin
                    n_checks++;
                    if (get_dv(w) !== 1'b1 || get_dout(w) !== exp) begin
                        n_fail++;
                        $display("FAIL hold dut%0d: data_out=%h valid=%b, required %h valid=1",
                                 w, get_dout(w), get_dv(w), exp);
                    end
                    tick();
                end
                n_checks++;
                if (get_dout(w) !== exp) begin
                    n_fail++;
                    $display("FAIL byte dut%0d: data_out=%h, required %h", w, get_dout(w), exp);
                end
                set_ready(w, 1'b1);
                tick();
                set_ready(w, stall == 0);
                waited++;
            end
        end
        n_checks++;
        if (qsize(w) != 0) begin
            n_fail++;
            $display("FAIL drain_timeout dut%0d: %0d bytes outstanding, required 0", w, qsize(w));
            if (w) exp_b.delete();
            else   exp_a.delete();
        end
    endtask

    task automatic check_idle_after(input bit w, input string name);
        n_checks++;
        if (get_dv(w) !== 1'b0 || get_rdy(w) !== 1'b1) begin
            n_fail++;
            $display("FAIL %s dut%0d: valid=%b ready=%b, required valid=0 ready=1",
                     name, w, get_dv(w), get_rdy(w));
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (a_rdy !== 1'b1 || a_err !== 1'b0 || a_dout !== 8'h00 || a_dv !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: ready=%b err=%b dout=%h valid=%b, required 1 0 00 0",
                     a_rdy, a_err, a_dout, a_dv);
        end
        n_checks++;
        if (b_rdy !== 1'b1 || b_err !== 1'b0 || b_dout !== 8'h00 || b_dv !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b: ready=%b err=%b dout=%h valid=%b, required 1 0 00 0",
                     b_rdy, b_err, b_dout, b_dv);
        end
    endtask

    task automatic test_three_byte();
        int gap;
        a_dr = 1'b1;
        send(0, 4'hB, 4'h0, 8'h10, 8'h0A, 1'b1);
        drain(0, 0, gap);
        n_checks++;
        if (gap != 0) begin
            n_fail++;
            $display("FAIL three_byte_latency: %0d idle cycles, required 0", gap);
        end
        check_idle_after(0, "three_byte_end");
    endtask

    task automatic test_backpressure();
        int gap;
        a_dr = 1'b0;
        send(0, 4'h9, 4'h3, 8'h3C, 8'h50, 1'b1);
        drain(0, 5, gap);
        check_idle_after(0, "backpressure_end");
    endtask

    task automatic test_program_change();
        int gap;
        a_dr = 1'b1;
        send(0, 4'hC, 4'h1, 8'h85, 8'h77, 1'b1);
        drain(0, 0, gap);
        check_idle_after(0, "program_change_end");
    endtask

    task automatic test_invalid();
        logic [3:0] bad[2] = '{4'h5, 4'hF};
        a_dr = 1'b1;
        foreach (bad[i]) begin
            send(0, bad[i], 4'h2, 8'h11, 8'h22, 1'b1);
            n_checks++;
            if (a_err !== 1'b1 || a_dv !== 1'b0 || a_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL invalid_pulse type %h: err=%b valid=%b ready=%b, required 1 0 1",
                         bad[i], a_err, a_dv, a_rdy);
            end
            tick();
            n_checks++;
            if (a_err !== 1'b0 || a_dv !== 1'b0) begin
                n_fail++;
                $display("FAIL invalid_after type %h: err=%b valid=%b, required 0 0",
                         bad[i], a_err, a_dv);
            end
        end
    endtask

    task automatic test_type_table();
        int gap;
        a_dr = 1'b1;
        for (int t = 8; t <= 14; t++) begin
            send(0, 4'(t), 4'(t - 8), 8'($urandom) | 8'h80, 8'($urandom), 1'b1);
            drain(0, 0, gap);
            n_checks++;
            if (gap != 0) begin
                n_fail++;
                $display("FAIL type_table_gap type %h: %0d idle cycles, required 0", t, gap);
            end
            check_idle_after(0, "type_table_end");
        end
    endtask

    task automatic test_running_status();
        int gap;
        b_dr = 1'b1;
        send(1, 4'h9, 4'h0, 8'h3C, 8'h50, 1'b1);
        drain(1, 0, gap);
        send(1, 4'h9, 4'h0, 8'h3E, 8'h50, 1'b0);
        drain(1, 0, gap);
        n_checks++;
        if (gap != 0) begin
            n_fail++;
            $display("FAIL rs_skip_latency: %0d idle cycles, required 0", gap);
        end
        repeat (3) tick();
        send(1, 4'h5, 4'h0, 8'h00, 8'h00, 1'b0);
        n_checks++;
        if (b_err !== 1'b1) begin
            n_fail++;
            $display("FAIL rs_invalid_err: err=%b, required 1", b_err);
        end
        send(1, 4'h9, 4'h0, 8'h40, 8'h20, 1'b0);
        drain(1, 0, gap);
        repeat (10) tick();
        send(1, 4'h9, 4'h0, 8'h3C, 8'h50, 1'b1);
        drain(1, 0, gap);
        send(1, 4'h8, 4'h0, 8'h3C, 8'h00, 1'b1);
        drain(1, 0, gap);
        send(1, 4'h8, 4'h0, 8'h3D, 8'h00, 1'b0);
        drain(1, 0, gap);
        check_idle_after(1, "rs_end");
    endtask

    task automatic test_async_reset();
        int gap;
        logic [7:0] exp;
        b_dr = 1'b1;
        send(1, 4'h9, 4'h0, 8'h3C, 8'h50, 1'b1);
        exp = exp_b.pop_front();
        n_checks++;
        if (b_dv !== 1'b1 || b_dout !== exp) begin
            n_fail++;
            $display("FAIL abort_status: dout=%h valid=%b, required %h valid=1", b_dout, b_dv, exp);
        end
        tick();
        exp = exp_b.pop_front();
        n_checks++;
        if (b_dv !== 1'b1 || b_dout !== exp) begin
            n_fail++;
            $display("FAIL abort_data1: dout=%h valid=%b, required %h valid=1", b_dout, b_dv, exp);
        end
        b_dr = 1'b0;
        exp_b.delete();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (b_dv !== 1'b0 || b_rdy !== 1'b1 || b_dout !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b ready=%b dout=%h, required 0 1 00",
                     b_dv, b_rdy, b_dout);
        end
        tick();
        rst_n = 1'b1;
        tick();
        b_dr = 1'b1;
        send(1, 4'h9, 4'h0, 8'h11, 8'h22, 1'b1);
        drain(1, 0, gap);
        check_idle_after(1, "post_reset_end");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_type = 4'h0; a_ch = 4'h0; a_d1 = 8'h00; a_d2 = 8'h00; a_valid = 1'b0; a_dr = 1'b0;
        b_type = 4'h0; b_ch = 4'h0; b_d1 = 8'h00; b_d2 = 8'h00; b_valid = 1'b0; b_dr = 1'b0;
        repeat (2) tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_three_byte();
        test_backpressure();
        test_program_change();
        test_invalid();
        test_type_table();
        test_running_status();
        test_async_reset();
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/midi_encoder.md
Name: midi_encoder

Overview:
- Serialises one MIDI channel-voice message per handshake into a stream of 8-bit bytes for the UART transmit path.
- Forms the transmit side of the MIDI link; its byte stream is what the MIDI decoder consumes. It also lets the board echo parameter changes and notes to external gear.
- Supports optional running-status compression with an idle timeout.

Parameters:
- RUNNING_STATUS, 0, 1 = omit the status byte when it equals the last status byte sent; 0 = always send it.
- RS_TIMEOUT, 15_000_000, idle cycles (no byte transferred) after which the running-status memory is cleared; 300 ms at 50 MHz.

Ports:
- clock_50_000_000  input  1  system clock
- reset_l  input  1  asynchronous active-low reset
- msg_type  input  4  status high nibble; valid values 0x8–0xE
- msg_channel  input  4  MIDI channel 0–15
- msg_data1  input  8  first data byte; bit 7 is ignored
- msg_data2  input  8  second data byte; bit 7 is ignored
- msg_valid  input  1  message fields are valid
- msg_ready  output  1  encoder can accept a message
- msg_error  output  1  one-cycle pulse: accepted message had msg_type < 0x8 or 0xF and was dropped
- data_out  output  8  byte to transmit
- data_out_valid  output  1  data_out is valid
- data_out_ready  input  1  downstream transmitter accepts a byte

Behaviour:
- Reset values: msg_ready=1, msg_error=0, data_out=0, data_out_valid=0, FSM=IDLE, running-status register=none, timeout counter=0.
- Reset is asynchronous. Asserting it mid-message aborts the message; the partial byte stream is not resumed.
- States: IDLE, STATUS, DATA1, DATA2.
- msg_ready=1 only in IDLE. A message is accepted on any cycle where msg_valid && msg_ready.
- Acceptance latches all fields and classifies length:
  - 0x8, 0x9, 0xA, 0xB, 0xE: 3 bytes.
  - 0xC, 0xD: 2 bytes.
  - anything else: invalid.
- Invalid type: msg_error pulses the following cycle, the FSM stays in IDLE, and nothing is output.
- Status byte = {msg_type, msg_channel}.
- After acceptance:
  - Next state is STATUS, except when RUNNING_STATUS=1 and the status byte equals the stored running status; then it skips to DATA1.
- Output register timing:
  - data_out and data_out_valid are registered; data_out_valid rises the cycle after acceptance.
  - A byte transfers when data_out_valid && data_out_ready.
  - data_out holds stable while data_out_valid=1 and data_out_ready=0.
- Transitions on transfer:
  - STATUS → DATA1.
  - DATA1 → DATA2 for 3-byte messages; DATA1 → IDLE for 2-byte messages.
  - DATA2 → IDLE.
- Data bytes are sent as {1'b0, data[6:0]}.
- Back-to-back: on the transfer of the last byte, data_out_valid drops and msg_ready rises the next cycle. Minimum spacing is one idle output cycle per message.
- Running status:
  - Updated to the status byte whenever a status byte transfers.
  - The timeout counter resets on every byte transfer and counts in every other cycle, saturating at RS_TIMEOUT.
  - On reaching RS_TIMEOUT the running status is cleared, so the next message re-sends its status byte.
  - When RUNNING_STATUS=0 the register is unused and the status byte is always sent.
- Invalid messages do not affect the running status.
- msg_* inputs are ignored outside acceptance; changes to them mid-message have no effect.

Test Plan:
1. RUNNING_STATUS=0, data_out_ready=1: type=0xB ch=0 d1=0x10 d2=0x0A → data_out 0xB0, 0x10, 0x0A on 3 consecutive cycles, first valid 1 cycle after accept; then msg_ready=1.
2. Backpressure: type=0x9 ch=3 d1=0x3C d2=0x50, data_out_ready low 5 cycles on each byte → 0x93, 0x3C, 0x50 each held stable until ready; no byte lost or duplicated.
3. Program change: type=0xC ch=1 d1=0x85 → 0xC1, 0x05 (bit 7 masked); 2 bytes only, then IDLE.
4. Invalid: type=0x5 → msg_error pulse one cycle, data_out_valid stays 0, msg_ready=1 next cycle.
5. RUNNING_STATUS=1, RS_TIMEOUT=8: two NOTE_ON ch0 back-to-back → 0x90,0x3C,0x50,0x3E,0x50; wait 10 idle cycles then NOTE_ON ch0 → 0x90 re-sent; NOTE_OFF after that → 0x80 sent.
6. Reset asserted while DATA1 is valid → data_out_valid=0 and msg_ready=1 immediately (asynchronous); the next message sends its full status byte.
